// File: rtl/l1_thresh_sequencer_if.sv
// rtl/l1_thresh_sequencer_if.sv - threshold-store read port and L1 trigger load bus
interface l1_thresh_sequencer_if #(
  parameter int NBEAMS      = 2,
  parameter int THRESH_BITS = 18
);
  localparam int AW = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;

  logic                   start_i;
  logic                   rd_en_o;
  logic [AW-1:0]          rd_addr_o;
  logic [THRESH_BITS-1:0] rd_data_i;
  logic [THRESH_BITS-1:0] thresh_o;
  logic [NBEAMS-1:0]      thresh_ce_o;
  logic                   update_o;
  logic                   trig_mask_o;
  logic                   busy_o;
  logic                   done_o;

  modport master (
    input  start_i, rd_data_i,
    output rd_en_o, rd_addr_o, thresh_o, thresh_ce_o, update_o, trig_mask_o, busy_o, done_o
  );

  modport slave (
    output start_i, rd_data_i,
    input  rd_en_o, rd_addr_o, thresh_o, thresh_ce_o, update_o, trig_mask_o, busy_o, done_o
  );
endinterface

// File: rtl/l1_thresh_sequencer.sv
// rtl/l1_thresh_sequencer.sv - reloads per-beam L1 trigger thresholds from a store and commits them
module l1_thresh_sequencer #(
  parameter int NBEAMS      = 2,
  parameter int THRESH_BITS = 18,
  parameter int HOLDOFF     = 16
) (
  input  logic aclk,
  input  logic aresetn,
  l1_thresh_sequencer_if.master bus
);
  localparam int AW = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
  localparam logic [AW-1:0]     LAST_BEAM = AW'(NBEAMS - 1);
  localparam logic [NBEAMS-1:0] CE_ONE    = NBEAMS'(1);
  localparam logic [15:0]       HOLD_INIT = 16'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [2:0] {IDLE, RD, LD, UPD, HOLD, FIN} state_t;

  state_t        state;
  logic [AW-1:0] k;
  logic [15:0]   hold_cnt;
  logic          pending;
  logic          armed;

  // The done_o cycle is spent in IDLE, so a pending or fresh request restarts right after it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state           <= IDLE;
      k               <= '0;
      hold_cnt        <= '0;
      pending         <= 1'b0;
      armed           <= 1'b0;
      bus.rd_en_o     <= 1'b0;
      bus.rd_addr_o   <= '0;
      bus.thresh_o    <= '0;
      bus.thresh_ce_o <= '0;
      bus.update_o    <= 1'b0;
      bus.trig_mask_o <= 1'b0;
      bus.busy_o      <= 1'b0;
      bus.done_o      <= 1'b0;
    end else begin
      armed           <= 1'b1;
      bus.rd_en_o     <= 1'b0;
      bus.rd_addr_o   <= '0;
      bus.thresh_ce_o <= '0;
      bus.update_o    <= 1'b0;
      bus.done_o      <= 1'b0;
      if (state != IDLE && bus.start_i) pending <= 1'b1;
      case (state)
        IDLE: begin
          if ((armed && bus.start_i) || pending) begin
            state       <= RD;
            k           <= '0;
            pending     <= 1'b0;
            bus.rd_en_o <= 1'b1;
            bus.busy_o  <= 1'b1;
          end
        end
        RD: state <= LD;
        LD: begin
          bus.thresh_o    <= bus.rd_data_i;
          bus.thresh_ce_o <= CE_ONE << k;
          bus.trig_mask_o <= 1'b1;
          if (k == LAST_BEAM) begin
            state <= UPD;
          end else begin
            k             <= k + 1'b1;
            bus.rd_en_o   <= 1'b1;
            bus.rd_addr_o <= k + 1'b1;
            state         <= RD;
          end
        end
        UPD: begin
          bus.update_o <= 1'b1;
          hold_cnt     <= HOLD_INIT;
          state        <= (HOLDOFF == 0) ? FIN : HOLD;
        end
        HOLD: begin
          if (hold_cnt == 16'd0) state <= FIN;
          else hold_cnt <= hold_cnt - 16'd1;
        end
        FIN: begin
          bus.busy_o      <= 1'b0;
          bus.trig_mask_o <= 1'b0;
          bus.done_o      <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l1_thresh_sequencer.sv
// tb/tb_l1_thresh_sequencer.sv - scoreboard bench for l1_thresh_sequencer
module tb_l1_thresh_sequencer;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  l1_thresh_sequencer_if #(.NBEAMS(2), .THRESH_BITS(18)) if0 ();
  l1_thresh_sequencer_if #(.NBEAMS(2), .THRESH_BITS(18)) if1 ();
  l1_thresh_sequencer_if #(.NBEAMS(1), .THRESH_BITS(18)) if2 ();

  l1_thresh_sequencer #(.NBEAMS(2), .THRESH_BITS(18), .HOLDOFF(16)) u0 (.aclk(aclk), .aresetn(aresetn), .bus(if0.master));
  l1_thresh_sequencer #(.NBEAMS(2), .THRESH_BITS(18), .HOLDOFF(0))  u1 (.aclk(aclk), .aresetn(aresetn), .bus(if1.master));
  l1_thresh_sequencer #(.NBEAMS(1), .THRESH_BITS(18), .HOLDOFF(4))  u2 (.aclk(aclk), .aresetn(aresetn), .bus(if2.master));

  logic        st [3];
  logic [17:0] rdd [3];
  assign if0.start_i = st[0];
  assign if1.start_i = st[1];
  assign if2.start_i = st[2];
  assign if0.rd_data_i = rdd[0];
  assign if1.rd_data_i = rdd[1];
  assign if2.rd_data_i = rdd[2];

  logic m_rd [3], m_upd [3], m_mask [3], m_busy [3], m_done [3];
  int   m_addr [3], m_ce [3], m_thr [3];
  assign m_rd[0] = if0.rd_en_o;   assign m_rd[1] = if1.rd_en_o;   assign m_rd[2] = if2.rd_en_o;
  assign m_upd[0] = if0.update_o; assign m_upd[1] = if1.update_o; assign m_upd[2] = if2.update_o;
  assign m_mask[0] = if0.trig_mask_o; assign m_mask[1] = if1.trig_mask_o; assign m_mask[2] = if2.trig_mask_o;
  assign m_busy[0] = if0.busy_o;  assign m_busy[1] = if1.busy_o;  assign m_busy[2] = if2.busy_o;
  assign m_done[0] = if0.done_o;  assign m_done[1] = if1.done_o;  assign m_done[2] = if2.done_o;
  assign m_addr[0] = int'(if0.rd_addr_o); assign m_addr[1] = int'(if1.rd_addr_o); assign m_addr[2] = int'(if2.rd_addr_o);
  assign m_ce[0] = int'(if0.thresh_ce_o); assign m_ce[1] = int'(if1.thresh_ce_o); assign m_ce[2] = int'(if2.thresh_ce_o);
  assign m_thr[0] = int'(if0.thresh_o);   assign m_thr[1] = int'(if1.thresh_o);   assign m_thr[2] = int'(if2.thresh_o);

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // event kinds: 0 read, 1 load, 2 update, 3 mask rise, 4 mask fall, 5 busy rise, 6 busy fall, 7 done
  typedef struct {int dut; int cyc; int kind; int val;} ev_t;
  ev_t exp_q[$];

  function automatic int store_val(int d, int k);
    if (d == 2) return 'h2A5A5;
    return (k == 0) ? 'h00123 : 'h3FFFF;
  endfunction

  task automatic push(int d, int c, int kd, int v);
    ev_t e;
    e.dut = d; e.cyc = c; e.kind = kd; e.val = v;
    exp_q.push_back(e);
  endtask

  // Expected events of one sequence started at cycle base, keeping only those before base+cut.
  task automatic gen(int d, int base, int nb, int h, int cut);
    int last;
    last = 2 * nb + 3 + h;
    for (int r = 0; r <= last && r < cut; r++) begin
      if (r % 2 == 1 && r <= 2 * nb - 1) push(d, base + r, 0, (r - 1) / 2);
      if (r % 2 == 1 && r >= 3 && r <= 2 * nb + 1)
        push(d, base + r, 1, ((1 << ((r - 3) / 2)) << 20) | store_val(d, (r - 3) / 2));
      if (r == 2 * nb + 2) push(d, base + r, 2, 0);
      if (r == 3)          push(d, base + r, 3, 0);
      if (r == last)       push(d, base + r, 4, 0);
      if (r == 1)          push(d, base + r, 5, 0);
      if (r == last)       push(d, base + r, 6, 0);
      if (r == last)       push(d, base + r, 7, 0);
    end
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic got(int d, int kd, int v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event unexpected dut%0d kind%0d val %0h at cycle %0d", d, kd, v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.dut != d || e.cyc != cyc || e.kind != kd || e.val != v) begin
        errors++;
        $display("FAIL event actual dut%0d cyc%0d kind%0d val %0h expected dut%0d cyc%0d kind%0d val %0h",
                 d, cyc, kd, v, e.dut, e.cyc, e.kind, e.val);
      end
    end
  endtask

  logic p_rd [3], p_mask [3], p_busy [3];
  int   p_addr [3], last_thr [3];

  always @(negedge aclk) begin
    for (int d = 0; d < 3; d++) begin
      if (m_rd[d]) got(d, 0, m_addr[d]);
      if (m_ce[d] != 0) got(d, 1, (m_ce[d] << 20) | m_thr[d]);
      if (m_upd[d]) got(d, 2, 0);
      if (m_mask[d] && !p_mask[d]) got(d, 3, 0);
      if (!m_mask[d] && p_mask[d]) got(d, 4, 0);
      if (m_busy[d] && !p_busy[d]) got(d, 5, 0);
      if (!m_busy[d] && p_busy[d]) got(d, 6, 0);
      if (m_done[d]) got(d, 7, 0);
      if (!m_rd[d]) chk("rd_addr_idle", m_addr[d], 0);
      chk("ce_onehot", int'($countones(m_ce[d]) <= 1), 1);
      if (!aresetn) last_thr[d] = 0;
      if (m_ce[d] == 0) chk("thresh_hold", m_thr[d], last_thr[d]);
      else last_thr[d] = m_thr[d];
      // store answers the cycle after a read strobe; any other cycle carries junk
      rdd[d] = p_rd[d] ? 18'(store_val(d, p_addr[d])) : 18'h15555;
      p_rd[d]   = m_rd[d];
      p_addr[d] = m_addr[d];
      p_mask[d] = m_mask[d];
      p_busy[d] = m_busy[d];
    end
  end

  task automatic pulse(int d);
    st[d] = 1'b1;
    @(negedge aclk);
    st[d] = 1'b0;
  endtask

  int base;

  initial begin
    for (int d = 0; d < 3; d++) begin
      st[d] = 1'b0; rdd[d] = 18'h15555;
      p_rd[d] = 1'b0; p_mask[d] = 1'b0; p_busy[d] = 1'b0;
      p_addr[d] = 0; last_thr[d] = 0;
    end
    repeat (3) @(negedge aclk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_rd_en", int'(m_rd[d]), 0);
      chk("reset_ce", m_ce[d], 0);
      chk("reset_thresh", m_thr[d], 0);
      chk("reset_update", int'(m_upd[d]), 0);
      chk("reset_mask", int'(m_mask[d]), 0);
      chk("reset_busy", int'(m_busy[d]), 0);
      chk("reset_done", int'(m_done[d]), 0);
    end
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    gen(0, cyc, 2, 16, 1000);
    pulse(0);
    repeat (28) @(negedge aclk);

    gen(1, cyc, 2, 0, 1000);
    pulse(1);
    repeat (10) @(negedge aclk);

    gen(2, cyc, 1, 4, 1000);
    pulse(2);
    repeat (12) @(negedge aclk);

    base = cyc;
    gen(0, base, 2, 16, 1000);
    gen(0, base + 23, 2, 16, 1000);
    for (int r = 0; r <= 23; r++) begin
      st[0] = (r == 0 || r == 4 || r == 10 || r == 23);
      @(negedge aclk);
    end
    st[0] = 1'b0;
    repeat (30) @(negedge aclk);

    base = cyc;
    gen(0, base, 2, 16, 4);
    push(0, base + 4, 4, 0);
    push(0, base + 4, 6, 0);
    pulse(0);
    repeat (2) @(negedge aclk);
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    st[0] = 1'b1;
    #1;
    chk("abort_thresh", int'(if0.thresh_o), 0);
    chk("abort_mask", int'(if0.trig_mask_o), 0);
    chk("abort_busy", int'(if0.busy_o), 0);
    chk("abort_ce", int'(if0.thresh_ce_o), 0);
    chk("abort_update", int'(if0.update_o), 0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    st[0] = 1'b0;
    repeat (40) @(negedge aclk);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
